// File: rtl/ppi_pkg.sv
// ppi_pkg: shared state encoding and control-word field positions for the 8255A Port A Mode 1 block
package ppi_pkg;
  typedef enum logic [2:0] {IDLE, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL, OUT_ACKED} state_e;
  localparam int MODE_FLAG = 7;
  localparam int GA_MODE_HI = 6;
  localparam int GA_MODE_LO = 5;
  localparam int PA_DIR = 4;
  localparam logic [2:0] INTE_A_IN = 3'd4;
  localparam logic [2:0] INTE_A_OUT = 3'd6;
  localparam logic [1:0] MODE1 = 2'b01;
endpackage

// File: rtl/ppi_sync_edge.sv
// ppi_sync_edge: multi-flop synchronizer with one-cycle fall/rise pulses on an async active-low pin
// Ports: clk, rst_n (async active-low), in_i (async pin), fall_o / rise_o (one-cycle pulses).
// With PPI_STB_FILTER_EN a fall is only reported after FILTER_LEN consecutive low samples;
// FILTER_LEN=1 is plain edge detection.
module ppi_sync_edge #(
  parameter int SYNC_STAGES = 2
`ifdef PPI_STB_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic fall_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  logic lvl;
  assign lvl = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= lvl;
    end
  assign rise_o = ~prev_q & lvl;
`ifdef PPI_STB_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILTER_LEN);
  localparam logic [CW-1:0] FHIT = CW'(FILTER_LEN - 1);
  logic [CW-1:0] cnt_q;
  // counts low samples already seen; saturating so the fall fires exactly once per low period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= lvl ? '0 : (cnt_q == FMAX ? cnt_q : cnt_q + 1'b1);
  assign fall_o = ~lvl && cnt_q == FHIT;
`else
  assign fall_o = prev_q & ~lvl;
`endif
endmodule

// File: rtl/ppi_porta_mode1_ctrl.sv
// ppi_porta_mode1_ctrl: 8255A Port A Mode 1 strobed-I/O control word decode and STB/ACK handshake
// Ports: ctrl_wr/bus_cpu control words; wr_a/rd_a/cpu_data_in CPU side; port_a_in, stb_a_n, ack_a_n
// pin side; port_a_out/port_a_oe/cpu_data_out data; ibf_a, obf_a_n, intr_a, overrun_a, mode1_active status.
// Optional macro PPI_STB_FILTER_EN adds a FILTER_LEN low-sample glitch filter on STB.
module ppi_porta_mode1_ctrl
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PPI_STB_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_wr,
  input  logic [7:0] bus_cpu,
  input  logic       wr_a,
  input  logic       rd_a,
  input  logic [7:0] cpu_data_in,
  input  logic [7:0] port_a_in,
  input  logic       stb_a_n,
  input  logic       ack_a_n,
  output logic [7:0] port_a_out,
  output logic       port_a_oe,
  output logic [7:0] cpu_data_out,
  output logic       ibf_a,
  output logic       obf_a_n,
  output logic       intr_a,
  output logic       overrun_a,
  output logic       mode1_active
);
  state_e state_q, state_d;
  logic [7:0] out_q, out_d, din_q, din_d;
  logic oe_q, oe_d, ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d, ovr_q, ovr_d, m1_q, m1_d, inte_q, inte_d;
  logic stb_fall, stb_rise, ack_fall, ack_rise, in_mode, out_mode, mode1_sel;
  ppi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PPI_STB_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_stb (.clk(clk), .rst_n(rst_n), .in_i(stb_a_n), .fall_o(stb_fall), .rise_o(stb_rise));
  ppi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PPI_STB_FILTER_EN
    , .FILTER_LEN(1)
`endif
  ) u_ack (.clk(clk), .rst_n(rst_n), .in_i(ack_a_n), .fall_o(ack_fall), .rise_o(ack_rise));
  assign in_mode = state_q == IN_EMPTY || state_q == IN_FULL;
  assign out_mode = state_q == OUT_EMPTY || state_q == OUT_FULL || state_q == OUT_ACKED;
  assign mode1_sel = bus_cpu[GA_MODE_HI:GA_MODE_LO] == MODE1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      out_q <= '0;
      din_q <= '0;
      oe_q <= 1'b0;
      ibf_q <= 1'b0;
      obf_n_q <= 1'b1;
      intr_q <= 1'b0;
      ovr_q <= 1'b0;
      m1_q <= 1'b0;
      inte_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      din_q <= din_d;
      oe_q <= oe_d;
      ibf_q <= ibf_d;
      obf_n_q <= obf_n_d;
      intr_q <= intr_d;
      ovr_q <= ovr_d;
      m1_q <= m1_d;
      inte_q <= inte_d;
    end
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    din_d = din_q;
    oe_d = oe_q;
    ibf_d = ibf_q;
    obf_n_d = obf_n_q;
    intr_d = intr_q;
    ovr_d = ovr_q;
    m1_d = m1_q;
    inte_d = inte_q;
    if (ctrl_wr) begin
      if (bus_cpu[MODE_FLAG]) begin
        m1_d = mode1_sel;
        state_d = !mode1_sel ? IDLE : bus_cpu[PA_DIR] ? IN_EMPTY : OUT_EMPTY;
        oe_d = mode1_sel & ~bus_cpu[PA_DIR];
        ibf_d = 1'b0;
        obf_n_d = 1'b1;
        intr_d = 1'b0;
        ovr_d = 1'b0;
        inte_d = 1'b0;
      end else if ((in_mode && bus_cpu[3:1] == INTE_A_IN) || (out_mode && bus_cpu[3:1] == INTE_A_OUT)) begin
        inte_d = bus_cpu[0];
        intr_d = intr_q & bus_cpu[0];
      end
    end else begin
      case (state_q)
        IN_EMPTY: if (stb_fall) begin
          din_d = port_a_in;
          ibf_d = 1'b1;
          state_d = IN_FULL;
        end
        IN_FULL: if (rd_a) begin
          // a strobe landing with the read refills the buffer right after it empties
          intr_d = 1'b0;
          ibf_d = stb_fall;
          din_d = stb_fall ? port_a_in : din_q;
          state_d = stb_fall ? IN_FULL : IN_EMPTY;
        end else begin
          intr_d = stb_rise ? inte_q : intr_q;
          ovr_d = ovr_q | stb_fall;
        end
        OUT_EMPTY, OUT_ACKED: if (wr_a) begin
          out_d = cpu_data_in;
          obf_n_d = 1'b0;
          intr_d = 1'b0;
          state_d = OUT_FULL;
        end else if (state_q == OUT_ACKED && ack_rise) begin
          intr_d = inte_q;
          state_d = OUT_EMPTY;
        end
        OUT_FULL: begin
          out_d = wr_a ? cpu_data_in : out_q;
          obf_n_d = ack_fall | obf_n_q;
          state_d = ack_fall ? OUT_ACKED : OUT_FULL;
        end
        default: ;
      endcase
    end
  end
  assign port_a_out = out_q;
  assign port_a_oe = oe_q;
  assign cpu_data_out = din_q;
  assign ibf_a = ibf_q;
  assign obf_a_n = obf_n_q;
  assign intr_a = intr_q;
  assign overrun_a = ovr_q;
  assign mode1_active = m1_q;
endmodule

// File: tb/tb_ppi_porta_mode1_ctrl.sv
// tb_ppi_porta_mode1_ctrl: scoreboard bench for the Port A Mode 1 handshake controller
module tb_ppi_porta_mode1_ctrl;
  logic clk = 0, rst_n = 0, ctrl_wr = 0, wr_a = 0, rd_a = 0, stb_a_n = 1, ack_a_n = 1;
  logic [7:0] bus_cpu = 0, cpu_data_in = 0, port_a_in = 0;
  logic [7:0] port_a_out, cpu_data_out, exp_d;
  logic port_a_oe, ibf_a, obf_a_n, intr_a, overrun_a, mode1_active;
  logic [21:0] all_o;
  localparam logic [21:0] RST_V = {16'h0000, 6'b001000};
  int checks = 0, failures = 0;
  logic [7:0] sb[$];
  assign all_o = {port_a_out, cpu_data_out, port_a_oe, ibf_a, obf_a_n, intr_a, overrun_a, mode1_active};
  always #5 clk = ~clk;
  ppi_porta_mode1_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ctrl_wr(ctrl_wr), .bus_cpu(bus_cpu), .wr_a(wr_a), .rd_a(rd_a),
    .cpu_data_in(cpu_data_in), .port_a_in(port_a_in), .stb_a_n(stb_a_n), .ack_a_n(ack_a_n),
    .port_a_out(port_a_out), .port_a_oe(port_a_oe), .cpu_data_out(cpu_data_out), .ibf_a(ibf_a),
    .obf_a_n(obf_a_n), .intr_a(intr_a), .overrun_a(overrun_a), .mode1_active(mode1_active)
  );
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ctrl(input logic [7:0] w);
    bus_cpu = w;
    ctrl_wr = 1;
    tick(1);
    ctrl_wr = 0;
  endtask
  task automatic pulse_rd;
    rd_a = 1;
    tick(1);
    rd_a = 0;
  endtask
  task automatic write_a(input logic [7:0] d);
    cpu_data_in = d;
    wr_a = 1;
    sb.push_back(d);
    tick(1);
    wr_a = 0;
  endtask
  task automatic test_reset;
    tick(3);
    checks++; if (all_o !== RST_V) begin failures++; $display("FAIL reset_vals got %h exp %h", all_o, RST_V); end
    rst_n = 1;
    tick(2);
    checks++; if (all_o !== RST_V) begin failures++; $display("FAIL reset_hold got %h exp %h", all_o, RST_V); end
  endtask
  task automatic test_input;
    ctrl(8'hB0);
    checks++; if ({mode1_active, port_a_oe, obf_a_n} !== 3'b101) begin failures++; $display("FAIL modeset_in got %b exp 101", {mode1_active, port_a_oe, obf_a_n}); end
    ctrl(8'h09);
    port_a_in = 8'h5A;
    sb.push_back(8'h5A);
    stb_a_n = 0;
    tick(2);
    checks++; if (ibf_a !== 1'b0) begin failures++; $display("FAIL ibf_early got %b exp 0", ibf_a); end
    tick(1);
    checks++; if (ibf_a !== 1'b1) begin failures++; $display("FAIL ibf_fall3 got %b exp 1", ibf_a); end
    exp_d = sb.pop_front();
    checks++; if (cpu_data_out !== exp_d) begin failures++; $display("FAIL in_data got %h exp %h", cpu_data_out, exp_d); end
    tick(1);
    stb_a_n = 1;
    tick(2);
    checks++; if (intr_a !== 1'b0) begin failures++; $display("FAIL intr_early got %b exp 0", intr_a); end
    tick(1);
    checks++; if (intr_a !== 1'b1) begin failures++; $display("FAIL intr_rise3 got %b exp 1", intr_a); end
    pulse_rd;
    checks++; if ({ibf_a, intr_a} !== 2'b00) begin failures++; $display("FAIL rd_clear got %b exp 00", {ibf_a, intr_a}); end
  endtask
  task automatic test_overrun;
    port_a_in = 8'h5A;
    sb.push_back(8'h5A);
    stb_a_n = 0;
    for (int n = 0; n < 20 && ibf_a !== 1'b1; n++) tick(1);
    checks++; if (ibf_a !== 1'b1) begin failures++; $display("FAIL ibf_timeout got %b exp 1", ibf_a); end
    exp_d = sb.pop_front();
    checks++; if (cpu_data_out !== exp_d) begin failures++; $display("FAIL refill_data got %h exp %h", cpu_data_out, exp_d); end
    tick(1);
    stb_a_n = 1;
    tick(4);
    port_a_in = 8'hC3;
    stb_a_n = 0;
    tick(4);
    stb_a_n = 1;
    tick(4);
    checks++; if ({cpu_data_out, overrun_a, ibf_a} !== {8'h5A, 2'b11}) begin failures++; $display("FAIL overrun got %h exp %h", {cpu_data_out, overrun_a, ibf_a}, {8'h5A, 2'b11}); end
    port_a_in = 8'h96;
    sb.push_back(8'h96);
    stb_a_n = 0;
    tick(2);
    pulse_rd;
    exp_d = sb.pop_front();
    checks++; if ({ibf_a, intr_a, cpu_data_out} !== {2'b10, exp_d}) begin failures++; $display("FAIL rd_stb_same got %h exp %h", {ibf_a, intr_a, cpu_data_out}, {2'b10, exp_d}); end
    tick(1);
    stb_a_n = 1;
    tick(4);
    pulse_rd;
  endtask
  task automatic test_output;
    ctrl(8'hA0);
    checks++; if ({mode1_active, port_a_oe, obf_a_n, overrun_a, ibf_a} !== 5'b11100) begin failures++; $display("FAIL modeset_out got %b exp 11100", {mode1_active, port_a_oe, obf_a_n, overrun_a, ibf_a}); end
    ctrl(8'h0D);
    write_a(8'h3C);
    exp_d = sb.pop_front();
    checks++; if ({port_a_out, obf_a_n, port_a_oe} !== {exp_d, 2'b01}) begin failures++; $display("FAIL wr_out got %h exp %h", {port_a_out, obf_a_n, port_a_oe}, {exp_d, 2'b01}); end
    ack_a_n = 0;
    tick(2);
    checks++; if (obf_a_n !== 1'b0) begin failures++; $display("FAIL obf_early got %b exp 0", obf_a_n); end
    tick(1);
    checks++; if (obf_a_n !== 1'b1) begin failures++; $display("FAIL obf_ack3 got %b exp 1", obf_a_n); end
    tick(1);
    ack_a_n = 1;
    tick(2);
    checks++; if (intr_a !== 1'b0) begin failures++; $display("FAIL ointr_early got %b exp 0", intr_a); end
    tick(1);
    checks++; if (intr_a !== 1'b1) begin failures++; $display("FAIL ointr_rise3 got %b exp 1", intr_a); end
  endtask
  task automatic test_inte_off;
    ctrl(8'h0C);
    checks++; if (intr_a !== 1'b0) begin failures++; $display("FAIL inte_clr_drop got %b exp 0", intr_a); end
    write_a(8'h11);
    exp_d = sb.pop_front();
    checks++; if (port_a_out !== exp_d) begin failures++; $display("FAIL wr_11 got %h exp %h", port_a_out, exp_d); end
    ack_a_n = 0;
    tick(3);
    ack_a_n = 1;
    tick(4);
    checks++; if ({intr_a, obf_a_n} !== 2'b01) begin failures++; $display("FAIL no_intr got %b exp 01", {intr_a, obf_a_n}); end
    write_a(8'h22);
    void'(sb.pop_front());
    write_a(8'h77);
    exp_d = sb.pop_front();
    checks++; if ({port_a_out, obf_a_n} !== {exp_d, 1'b0}) begin failures++; $display("FAIL overwrite got %h exp %h", {port_a_out, obf_a_n}, {exp_d, 1'b0}); end
  endtask
  task automatic test_bsr_index;
    ctrl(8'hB0);
    ctrl(8'h0D);
    port_a_in = 8'hE1;
    sb.push_back(8'hE1);
    stb_a_n = 0;
    tick(4);
    stb_a_n = 1;
    exp_d = sb.pop_front();
    checks++; if (cpu_data_out !== exp_d) begin failures++; $display("FAIL bsr_data got %h exp %h", cpu_data_out, exp_d); end
    tick(4);
    checks++; if (intr_a !== 1'b0) begin failures++; $display("FAIL bsr_wrong_idx got %b exp 0", intr_a); end
    pulse_rd;
  endtask
  task automatic test_reset_mid;
    ctrl(8'hB0);
    ctrl(8'h09);
    port_a_in = 8'h44;
    stb_a_n = 0;
    tick(4);
    checks++; if (ibf_a !== 1'b1) begin failures++; $display("FAIL pre_rst_full got %b exp 1", ibf_a); end
    #2 rst_n = 0;
    #1;
    checks++; if (all_o !== RST_V) begin failures++; $display("FAIL async_rst got %h exp %h", all_o, RST_V); end
    tick(1);
    rst_n = 1;
    tick(1);
    ctrl(8'h80);
    stb_a_n = 1;
    tick(4);
    stb_a_n = 0;
    tick(4);
    stb_a_n = 1;
    ack_a_n = 0;
    tick(4);
    ack_a_n = 1;
    write_a(8'h05);
    void'(sb.pop_front());
    tick(4);
    checks++; if (all_o !== RST_V) begin failures++; $display("FAIL idle_ignore got %h exp %h", all_o, RST_V); end
  endtask
`ifdef PPI_STB_FILTER_EN
  task automatic test_filter;
    ctrl(8'hB0);
    port_a_in = 8'hBE;
    stb_a_n = 0;
    tick(2);
    stb_a_n = 1;
    tick(8);
    checks++; if ({ibf_a, overrun_a} !== 2'b00) begin failures++; $display("FAIL glitch got %b exp 00", {ibf_a, overrun_a}); end
    sb.push_back(8'hBE);
    stb_a_n = 0;
    tick(4);
    checks++; if (ibf_a !== 1'b0) begin failures++; $display("FAIL filt_early got %b exp 0", ibf_a); end
    tick(1);
    exp_d = sb.pop_front();
    checks++; if ({ibf_a, cpu_data_out} !== {1'b1, exp_d}) begin failures++; $display("FAIL filt_fall5 got %h exp %h", {ibf_a, cpu_data_out}, {1'b1, exp_d}); end
    stb_a_n = 1;
    tick(4);
  endtask
`endif
  initial begin
    test_reset;
    test_input;
    test_overrun;
    test_output;
    test_inte_off;
    test_bsr_index;
    test_reset_mid;
`ifdef PPI_STB_FILTER_EN
    test_filter;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ppi_porta_mode1_ctrl.md
Name: ppi_porta_mode1_ctrl

Overview:
- Sequences 8255A Port A in Mode 1 (strobed I/O).
- Decodes CPU control words: mode-set selects Mode 1 input or output; BSR writes set or clear INTE_A.
- Runs the STB/IBF/INTR input handshake or the OBF/ACK/INTR output handshake.
- Sits between the CPU-side control logic and the Port A pin buffers; drives Group A upper Port C status bits.

Parameters:
- SYNC_STAGES, 2, flops in each stb_a_n/ack_a_n synchronizer (min 2).
- FILTER_LEN, 3, consecutive low samples needed to accept STB (only with PPI_STB_FILTER_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ctrl_wr  input  1  one-cycle strobe; bus_cpu holds a control word
- bus_cpu  input  8  control word (D7=1 mode-set, D7=0 BSR)
- wr_a  input  1  one-cycle CPU write to Port A
- rd_a  input  1  one-cycle CPU read of Port A
- cpu_data_in  input  8  CPU write data
- port_a_in  input  8  Port A pins
- stb_a_n  input  1  peripheral strobe (PC4), asynchronous
- ack_a_n  input  1  peripheral acknowledge (PC6), asynchronous
- port_a_out  output  8  output latch
- port_a_oe  output  1  1 = Port A drives pins
- cpu_data_out  output  8  input latch
- ibf_a  output  1  input buffer full (PC5)
- obf_a_n  output  1  output buffer full, active low (PC7)
- intr_a  output  1  interrupt request (PC3)
- overrun_a  output  1  sticky: strobe arrived while IBF=1
- mode1_active  output  1  Port A is in Mode 1

Behaviour:
- Reset values: port_a_out=0, cpu_data_out=0, port_a_oe=0, ibf_a=0, obf_a_n=1, intr_a=0, overrun_a=0, mode1_active=0, INTE_A=0, state=IDLE, synchronizers=1.
- Mode-set (ctrl_wr, D7=1):
  - D6:5=01: mode1_active=1. D4=1 selects input (state IN_EMPTY, oe=0). D4=0 selects output (state OUT_EMPTY, oe=1).
  - D6:5 any other value: state IDLE, mode1_active=0.
  - Every mode-set forces ibf_a=0, obf_a_n=1, intr_a=0, overrun_a=0, INTE_A=0.
- BSR (ctrl_wr, D7=0): bit index=D3:1, value=D0.
  - Index 4 writes INTE_A in input mode. Index 6 writes INTE_A in output mode. Other indices are ignored.
  - Ignored in IDLE.
  - Clearing INTE_A drops intr_a on the next edge.
- Edge detection: on the synchronized signal, one-cycle fall/rise pulses. Pin-to-state latency is SYNC_STAGES+1 cycles.
- IN_EMPTY:
  - STB fall: latch port_a_in into cpu_data_out, ibf_a=1, go to IN_FULL.
- IN_FULL:
  - STB rise: intr_a=INTE_A.
  - rd_a: intr_a=0, ibf_a=0, go to IN_EMPTY.
  - STB fall while full: data not relatched, overrun_a=1.
  - rd_a and STB fall in the same cycle: the read completes, then new data latches. ibf_a stays 1, state IN_FULL, intr_a=0.
- OUT_EMPTY:
  - wr_a: port_a_out=cpu_data_in, obf_a_n=0, intr_a=0, go to OUT_FULL.
- OUT_FULL:
  - wr_a: overwrites port_a_out; obf_a_n stays 0.
  - ACK fall: obf_a_n=1, go to OUT_ACKED.
- OUT_ACKED:
  - ACK rise: intr_a=INTE_A, go to OUT_EMPTY.
  - wr_a: treated as in OUT_EMPTY (latch, obf_a_n=0, intr_a=0), go to OUT_FULL.
- IDLE: handshake inputs ignored; wr_a/rd_a are not handled here (Mode 0 path elsewhere).
- Simultaneous ctrl_wr and handshake event: ctrl_wr wins.
- rst_n assertion mid-handshake: immediate return to reset values.
- All outputs are registered.

Optional Feature:
- PPI_STB_FILTER_EN defined: a STB fall is accepted only after FILTER_LEN consecutive synchronized low samples. Latency becomes SYNC_STAGES+FILTER_LEN cycles. Low pulses shorter than FILTER_LEN are ignored (no latch, no overrun).
- Undefined: no filter; any synchronized fall counts.

Decomposition:
- Package ppi_pkg holds:
  - state enum (IDLE, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL, OUT_ACKED);
  - control-word field positions (MODE_FLAG=7, GA_MODE=6:5, PA_DIR=4);
  - BSR indices (INTE_A_IN=4, INTE_A_OUT=6);
  - mode code MODE1=2'b01.
- One sub-module, ppi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse generator (plus the optional filter). Instantiated for stb_a_n and ack_a_n.

Test Plan:
- Reset, then ctrl_wr 8'hB0 (mode 1 input), then 8'h09 (INTE_A=1); port_a_in=8'h5A, stb_a_n low 4 cycles -> ibf_a=1 at fall+3 cycles, cpu_data_out=8'h5A, intr_a=1 after stb_a_n rises; rd_a -> ibf_a=0, intr_a=0.
- Input mode with IBF=1, second strobe with port_a_in=8'hC3 -> cpu_data_out stays 8'h5A, overrun_a=1; rd_a and a third strobe fall landing in the same cycle -> ibf_a remains 1 with the new data.
- ctrl_wr 8'hA0 (mode 1 output) then 8'h0D (INTE_A=1); wr_a with 8'h3C -> port_a_out=8'h3C, obf_a_n=0, port_a_oe=1; ack_a_n pulse low -> obf_a_n=1 at fall+3, intr_a=1 at rise+3.
- Output mode, BSR 8'h0C (INTE_A=0), full ACK cycle -> intr_a stays 0; wr_a in OUT_FULL with 8'h77 overwrites to 8'h77.
- rst_n asserted in IN_FULL -> all outputs at reset values asynchronously; mode-set 8'h80 -> mode1_active=0, handshakes ignored.
- With PPI_STB_FILTER_EN, FILTER_LEN=3: 2-cycle stb_a_n glitch -> no latch; 5-cycle low -> ibf_a=1 at fall+5.
